// File: rtl/mp64_pm_pkg.sv
// Shared power-management definitions: FSM state encoding and default widths
// for the clock-gate controller.
package mp64_pm_pkg;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_GATED = 2'd2;
  localparam logic [1:0] ST_WAKE  = 2'd3;

  localparam int IDLE_W_DEF = 16;
  localparam int STAT_W_DEF = 32;

endpackage

// File: rtl/mp64_sat_counter.sv
// Up-counter that sticks at all-ones; clr has priority over inc.
module mp64_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !(&q)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/mp64_clkgate_ctrl.sv
// Drives the enable of one mp64_clkgate: gates the domain clock after an idle
// drain period and restarts it on wake requests, with a settle delay.
module mp64_clkgate_ctrl
  import mp64_pm_pkg::*;
#(
  parameter int IDLE_W    = IDLE_W_DEF,
  parameter int DRAIN_CYC = 4,
  parameter int WAKE_CYC  = 2,
  parameter int STAT_W    = STAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              idle,
  input  logic              sleep_req,
  input  logic              wake_req,
  input  logic              cfg_auto,
  input  logic [IDLE_W-1:0] cfg_idle_thresh,
  input  logic              stat_clr,
  output logic              gate_en,
  output logic              gated,
  output logic              wake_ack,
  output logic [1:0]        state,
  output logic [STAT_W-1:0] gated_cycles
);

  localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYC - 1);
  localparam logic [7:0] WAKE_LOAD  = 8'(WAKE_CYC - 1);

  logic [IDLE_W-1:0] icnt;
  logic [IDLE_W:0]   icnt_p1;
  logic              auto_hit;
  logic [7:0]        cnt;
  logic [7:0]        cnt_nxt;
  logic [1:0]        state_nxt;
  logic              ack_nxt;

  mp64_sat_counter #(.W(IDLE_W)) u_icnt (
    .clk (clk),
    .rst (rst),
    .clr ((state != ST_RUN) || !idle || !cfg_auto),
    .inc (1'b1),
    .q   (icnt)
  );

  mp64_sat_counter #(.W(STAT_W)) u_gated_cycles (
    .clk (clk),
    .rst (rst),
    .clr (stat_clr),
    .inc (state == ST_GATED),
    .q   (gated_cycles)
  );

  // One bit wider so a saturated icnt still compares correctly.
  assign icnt_p1  = {1'b0, icnt} + {{IDLE_W{1'b0}}, 1'b1};
  assign auto_hit = cfg_auto && (cfg_idle_thresh != '0) &&
                    (icnt_p1 >= {1'b0, cfg_idle_thresh});

  // A single down-counter times both the drain and the wake settle phases.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_nxt   = 1'b0;
    case (state)
      ST_RUN: begin
        if (!wake_req && idle && (sleep_req || auto_hit)) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (!idle || wake_req) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = ST_GATED;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      ST_GATED: begin
        if (wake_req) begin
          state_nxt = ST_WAKE;
          cnt_nxt   = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (cnt == '0) begin
          state_nxt = ST_RUN;
          ack_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      cnt      <= '0;
      gate_en  <= 1'b1;
      gated    <= 1'b0;
      wake_ack <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      gate_en  <= (state_nxt != ST_GATED);
      gated    <= (state_nxt == ST_GATED);
      wake_ack <= ack_nxt;
    end
  end

endmodule

// File: tb/tb_mp64_clkgate_ctrl.sv
// Directed bench for mp64_clkgate_ctrl with a behavioural latch-based gate
// model so gated-clock edges can be counted.
`timescale 1ns/1ps
module tb_mp64_clkgate_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        idle;
  logic        sleep_req;
  logic        wake_req;
  logic        cfg_auto;
  logic [15:0] cfg_idle_thresh;
  logic        stat_clr;
  logic        gate_en;
  logic        gated;
  logic        wake_ack;
  logic [1:0]  state;
  logic [31:0] gated_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  logic en_lat;
  logic gclk;
  int   gclk_edges = 0;

  always #5 clk = ~clk;

  always @(clk or gate_en) if (!clk) en_lat = gate_en;
  assign gclk = clk & en_lat;
  always @(posedge gclk) gclk_edges++;

  mp64_clkgate_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .idle            (idle),
    .sleep_req       (sleep_req),
    .wake_req        (wake_req),
    .cfg_auto        (cfg_auto),
    .cfg_idle_thresh (cfg_idle_thresh),
    .stat_clr        (stat_clr),
    .gate_en         (gate_en),
    .gated           (gated),
    .wake_ack        (wake_ack),
    .state           (state),
    .gated_cycles    (gated_cycles)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; idle = 1'b0; sleep_req = 1'b0; wake_req = 1'b0;
    cfg_auto = 1'b0; cfg_idle_thresh = 16'd0; stat_clr = 1'b0;
    tick(2);
    n_checks++;
    if ({gate_en, gated, wake_ack, state} !== 5'b10000 || gated_cycles !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: gate_en=%b gated=%b ack=%b state=%0d gc=%0d, want 1 0 0 0 0",
               gate_en, gated, wake_ack, state, gated_cycles);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      n_checks++;
      if ({gate_en, gated, state} !== 4'b1000 || gated_cycles !== 32'd0) begin
        n_fail++;
        $display("[TB] FAIL run_idle0 cyc %0d: gate_en=%b gated=%b state=%0d gc=%0d, want 1 0 0 0",
                 i, gate_en, gated, state, gated_cycles);
      end
    end
  endtask

  task automatic test_auto_gate();
    cfg_auto = 1'b1; cfg_idle_thresh = 16'd8; idle = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      n_checks++;
      if (state !== 2'd0) begin
        n_fail++;
        $display("[TB] FAIL auto_run idle cyc %0d: state=%0d, want 0", i, state);
      end
    end
    tick(1);
    n_checks++;
    if (state !== 2'd1 || gate_en !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL auto_drain_entry: state=%0d gate_en=%b, want 1 1", state, gate_en);
    end
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      n_checks++;
      if (state !== 2'd1 || gate_en !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL auto_drain cyc %0d: state=%0d gate_en=%b, want 1 1", i, state, gate_en);
      end
    end
    tick(1);
    n_checks++;
    if (state !== 2'd2 || gate_en !== 1'b0 || gated !== 1'b1 || gated_cycles !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL auto_gated: state=%0d gate_en=%b gated=%b gc=%0d, want 2 0 1 0",
               state, gate_en, gated, gated_cycles);
    end
    gclk_edges = 0;
  endtask

  task automatic test_wake();
    tick(49);
    n_checks++;
    if (state !== 2'd2 || gated_cycles !== 32'd49 || gclk_edges !== 0) begin
      n_fail++;
      $display("[TB] FAIL gated_hold: state=%0d gc=%0d gclk_edges=%0d, want 2 49 0",
               state, gated_cycles, gclk_edges);
    end
    wake_req = 1'b1; idle = 1'b0;
    tick(1);
    wake_req = 1'b0;
    n_checks++;
    if (state !== 2'd3 || gate_en !== 1'b1 || gated !== 1'b0 || wake_ack !== 1'b0 ||
        gated_cycles !== 32'd50) begin
      n_fail++;
      $display("[TB] FAIL wake_entry: state=%0d gate_en=%b gated=%b ack=%b gc=%0d, want 3 1 0 0 50",
               state, gate_en, gated, wake_ack, gated_cycles);
    end
    tick(1);
    n_checks++;
    if (state !== 2'd3 || wake_ack !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL wake_settle: state=%0d ack=%b, want 3 0", state, wake_ack);
    end
    tick(1);
    n_checks++;
    if (state !== 2'd0 || wake_ack !== 1'b1 || gate_en !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wake_ack_pulse: state=%0d ack=%b gate_en=%b, want 0 1 1", state, wake_ack, gate_en);
    end
    tick(1);
    n_checks++;
    if (wake_ack !== 1'b0 || gated_cycles !== 32'd50 || gclk_edges < 2) begin
      n_fail++;
      $display("[TB] FAIL wake_after: ack=%b gc=%0d gclk_edges=%0d, want 0 50 >=2",
               wake_ack, gated_cycles, gclk_edges);
    end
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    n_checks++;
    if (gated_cycles !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL stat_clr: gc=%0d, want 0", gated_cycles);
    end
  endtask

  task automatic test_drain_abort();
    cfg_auto = 1'b0; idle = 1'b1; sleep_req = 1'b1;
    tick(1);
    sleep_req = 1'b0;
    n_checks++;
    if (state !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL sleep_drain: state=%0d, want 1", state);
    end
    tick(1);
    idle = 1'b0;
    tick(1);
    n_checks++;
    if (state !== 2'd0 || gate_en !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL drain_abort: state=%0d gate_en=%b, want 0 1", state, gate_en);
    end
    sleep_req = 1'b1;
    tick(1);
    sleep_req = 1'b0;
    idle = 1'b1;
    tick(3);
    n_checks++;
    if (state !== 2'd0 || gate_en !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL sleep_dropped: state=%0d gate_en=%b, want 0 1", state, gate_en);
    end
    idle = 1'b1; sleep_req = 1'b1;
    tick(1);
    sleep_req = 1'b0; wake_req = 1'b1;
    tick(1);
    wake_req = 1'b0;
    n_checks++;
    if (state !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL drain_wake_abort: state=%0d, want 0", state);
    end
    cfg_auto = 1'b1; cfg_idle_thresh = 16'd1000;
    tick(5);
    cfg_idle_thresh = 16'd3;
    tick(1);
    n_checks++;
    if (state !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL thresh_lowered: state=%0d, want 1", state);
    end
    idle = 1'b0; cfg_auto = 1'b0;
    tick(1);
  endtask

  task automatic test_back_to_back();
    bit bad;
    idle = 1'b1; sleep_req = 1'b1; wake_req = 1'b1;
    tick(1);
    sleep_req = 1'b0; wake_req = 1'b0;
    n_checks++;
    if (state !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL wake_beats_sleep: state=%0d, want 0", state);
    end
    cfg_auto = 1'b1; cfg_idle_thresh = 16'd0;
    bad = 1'b0;
    for (int i = 0; i < 1000 && !bad; i++) begin
      tick(1);
      n_checks++;
      if (state !== 2'd0 || gate_en !== 1'b1) begin
        n_fail++;
        bad = 1'b1;
        $display("[TB] FAIL thresh0 cyc %0d: state=%0d gate_en=%b, want 0 1", i, state, gate_en);
      end
    end
    cfg_auto = 1'b0; idle = 1'b0;
    tick(1);
  endtask

  task automatic test_async_reset();
    idle = 1'b1; sleep_req = 1'b1;
    tick(1);
    sleep_req = 1'b0;
    tick(4);
    n_checks++;
    if (state !== 2'd2 || gated !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL sleep_gated: state=%0d gated=%b, want 2 1", state, gated);
    end
    tick(3);
    n_checks++;
    if (gated_cycles !== 32'd3) begin
      n_fail++;
      $display("[TB] FAIL gated_count: gc=%0d, want 3", gated_cycles);
    end
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    n_checks++;
    if (gated_cycles !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL clr_while_gated: gc=%0d, want 0", gated_cycles);
    end
    tick(1);
    n_checks++;
    if (gated_cycles !== 32'd1 || state !== 2'd2) begin
      n_fail++;
      $display("[TB] FAIL count_after_clr: gc=%0d state=%0d, want 1 2", gated_cycles, state);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({gate_en, gated, wake_ack, state} !== 5'b10000 || gated_cycles !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: gate_en=%b gated=%b ack=%b state=%0d gc=%0d, want 1 0 0 0 0",
               gate_en, gated, wake_ack, state, gated_cycles);
    end
    tick(2);
    rst = 1'b0; idle = 1'b0;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_auto_gate();
    test_wake();
    test_drain_abort();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
